// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch requester and a load/store
// requester onto one shared single-port memory whose read data appears
// MEM_LAT cycles (1..4) after the enable cycle.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters contend in IDLE. Without it, load/store always wins.
//
// Handshake: a requester raises req with its fields stable and holds them
// until it sees a one-cycle ack. The arbiter samples req only in IDLE. Once a
// grant is made the transaction runs to completion whatever req does
// afterwards. rdata is valid in the ack cycle and held until that requester's
// next read. A req still high in the cycle after ack is a new request.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        take_d;
  logic        in_issue;
  logic        in_resp;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e      last_q, last_d;

  // Under contention the requester not granted last wins; lone requests win outright.
  assign take_d = (d_req && if_req) ? (last_q == GNT_IF) : d_req;

  // Last-grant flag, refreshed on every grant made in IDLE.
  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && (if_req || d_req)) begin
      last_d = take_d ? GNT_D : GNT_IF;
    end
  end

  // Last-grant flag register; IF after reset so D wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: load/store beats instruction fetch.
  assign take_d = d_req;
`endif

  // Next-state logic: grant and latch in IDLE, count latency, single RESP cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d = ST_ISSUE;
          grant_d = take_d ? GNT_D : GNT_IF;
          addr_d  = take_d ? d_addr : if_addr;
          we_d    = take_d && d_we;
          wdata_d = (take_d && d_we) ? d_wdata : 32'h0;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        // Counter holds MEM_LAT on the first WAIT cycle; leaving at 2 lands
        // RESP exactly MEM_LAT cycles after the enable cycle.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd2) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  // Output decode: memory strobes only in ISSUE, acks only in RESP.
  always_comb begin
    mem_en     = in_issue;
    mem_we     = in_issue && we_q;
    mem_addr   = in_issue ? addr_q : 32'h0;
    mem_wdata  = in_issue ? wdata_q : 32'h0;
    if_ack     = in_resp && (grant_q == GNT_IF);
    d_ack      = in_resp && (grant_q == GNT_D);
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_ack) begin
      if_rdata_d = mem_rdata;
    end
    if (d_ack && !we_q) begin
      d_rdata_d = mem_rdata;
    end
    if_rdata    = if_rdata_d;
    d_rdata     = d_rdata_d;
    busy        = (state_q != ST_IDLE);
    dbg_state_o = state_q;
  end

  // State, latched request fields and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GNT_IF;
      cnt_q      <= 3'd0;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter instances (MEM_LAT = 1, 3, 4) sharing clock
// and reset, each with its own latency-accurate memory model. Expected
// responses are pushed to a scoreboard when a request is driven and popped
// when an ack appears.
module tb_mem_arbiter;

  localparam int N = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] pat(input int g, input int a);
    return {8'(g + 1), 8'(a), ~8'(a), 8'hC3};
  endfunction

  logic        clk;
  logic        rst;
  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic        if_ack    [N];
  logic [31:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_ack     [N];
  logic [31:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];
  logic [1:0]  dbg_state [N];

  logic [31:0] shadow    [N][256];
  logic [31:0] exp_if_rd [N];
  logic [31:0] exp_d_rd  [N];
  logic [32:0] exp_q[$];

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and memory models ----------------
  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    mem_arbiter #(.MEM_LAT(L)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req[g]),
      .if_addr     (if_addr[g]),
      .if_ack      (if_ack[g]),
      .if_rdata    (if_rdata[g]),
      .d_req       (d_req[g]),
      .d_we        (d_we[g]),
      .d_addr      (d_addr[g]),
      .d_wdata     (d_wdata[g]),
      .d_ack       (d_ack[g]),
      .d_rdata     (d_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g]),
      .busy        (busy[g]),
      .dbg_state_o (dbg_state[g])
    );

    initial begin
      for (int a = 0; a < 256; a++) mem[a] = pat(g, a);
    end

    // Read data emerges L cycles after the enable cycle; filler otherwise.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][9:2]] : (32'hBAD0_0000 | 32'(g));
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_rdata[g] = pipe[L-1];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      $error("check %s[%0d]", tag, i);
    end
  endtask

  // Pops the oldest expected response and compares {is_d, rdata}.
  task automatic sb_pop(input string tag, input int i, input logic [32:0] obs);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d] observed=%0h expected=queued-entry", tag, i, obs);
      $error("check %s[%0d]", tag, i);
    end else begin
      e = exp_q.pop_front();
      check(tag, i, 64'(obs), 64'(e));
    end
  endtask

  task automatic check_quiet(input string tag, input int i);
    check({tag, "_busy"}, i, 64'(busy[i]), 64'd0);
    check({tag, "_mem_en"}, i, 64'(mem_en[i]), 64'd0);
    check({tag, "_mem_we"}, i, 64'(mem_we[i]), 64'd0);
    check({tag, "_mem_addr"}, i, 64'(mem_addr[i]), 64'd0);
    check({tag, "_mem_wdata"}, i, 64'(mem_wdata[i]), 64'd0);
    check({tag, "_if_ack"}, i, 64'(if_ack[i]), 64'd0);
    check({tag, "_d_ack"}, i, 64'(d_ack[i]), 64'd0);
    check({tag, "_if_rdata"}, i, 64'(if_rdata[i]), 64'(exp_if_rd[i]));
    check({tag, "_d_rdata"}, i, 64'(d_rdata[i]), 64'(exp_d_rd[i]));
    check({tag, "_state"}, i, 64'(dbg_state[i]), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_if_rd[i] = 32'h0;
      exp_d_rd[i]  = 32'h0;
    end
  endtask

  // One single-requester transaction, checked cycle by cycle.
  task automatic txn(input int i, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit drop_early);
    int lat;
    bit wr;
    logic [31:0] exp_rd;
    lat = lat_of(i);
    wr  = is_d && we;
    @(negedge clk);
    if (is_d) begin
      d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
    end else begin
      if_req[i] = 1'b1; if_addr[i] = addr;
    end
    if (wr) begin
      exp_rd = exp_d_rd[i];
      shadow[i][addr[9:2]] = wdata;
    end else begin
      exp_rd = shadow[i][addr[9:2]];
    end
    exp_q.push_back({is_d, exp_rd});
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check("busy", i, 64'(busy[i]), 64'd1);
      check("mem_en", i, 64'(mem_en[i]), 64'(k == 1));
      check("state", i, 64'(dbg_state[i]), (k == 1) ? 64'd1 : ((k == lat + 1) ? 64'd3 : 64'd2));
      if (k == 1) begin
        check("mem_addr", i, 64'(mem_addr[i]), 64'(addr));
        check("mem_we", i, 64'(mem_we[i]), 64'(wr));
        check("mem_wdata", i, 64'(mem_wdata[i]), wr ? 64'(wdata) : 64'd0);
        if (drop_early) begin
          if_req[i] = 1'b0; d_req[i] = 1'b0;
          if_addr[i] = ~addr; d_addr[i] = ~addr; d_wdata[i] = ~wdata; d_we[i] = ~we;
        end
      end else begin
        check("mem_addr_idle", i, 64'(mem_addr[i]), 64'd0);
      end
      if (k < lat + 1) begin
        check("early_ack", i, 64'({if_ack[i], d_ack[i]}), 64'd0);
      end else begin
        check("if_ack", i, 64'(if_ack[i]), 64'(!is_d));
        check("d_ack", i, 64'(d_ack[i]), 64'(is_d));
        sb_pop("resp", i, {d_ack[i], is_d ? d_rdata[i] : if_rdata[i]});
        if (is_d) exp_d_rd[i] = exp_rd;
        else      exp_if_rd[i] = exp_rd;
        if_req[i] = 1'b0; d_req[i] = 1'b0;
      end
    end
    @(negedge clk);
    check_quiet("post", i);
  endtask

  // Both requesters held for n grants; checks grant order and spacing.
  task automatic both_req(input int i, input int n);
    int lat;
    int period;
    int acks;
    bit is_d;
    lat = lat_of(i);
    period = lat + 2;
    acks = 0;
    @(negedge clk);
    if_req[i] = 1'b1; if_addr[i] = 32'h0000_0040;
    d_req[i]  = 1'b1; d_we[i] = 1'b0; d_addr[i] = 32'h0000_0080;
    for (int j = 0; j < n; j++) begin
`ifdef ARB_ROUND_ROBIN_EN
      is_d = (j % 2 == 0);
`else
      is_d = 1'b1;
`endif
      exp_q.push_back({is_d, is_d ? shadow[i][32] : shadow[i][16]});
    end
    for (int k = 1; k <= n * period + 2 && acks < n; k++) begin
      @(negedge clk);
      if (k == lat + 1 + acks * period) begin
        check("both_one_ack", i, 64'(if_ack[i] ^ d_ack[i]), 64'd1);
        sb_pop("both_resp", i, {d_ack[i], d_ack[i] ? d_rdata[i] : if_rdata[i]});
        if (d_ack[i]) exp_d_rd[i] = shadow[i][32];
        if (if_ack[i]) exp_if_rd[i] = shadow[i][16];
        acks++;
        if (acks == n) begin
          if_req[i] = 1'b0; d_req[i] = 1'b0;
        end
      end else begin
        check("both_no_ack", i, 64'({if_ack[i], d_ack[i]}), 64'd0);
      end
    end
    @(negedge clk);
    check_quiet("both_post", i);
  endtask

  // Reset during WAIT: aborts with no ack; req held through the reset edge is ignored.
  task automatic reset_mid(input int i);
    @(negedge clk);
    if_req[i] = 1'b1; if_addr[i] = 32'h0000_0020;
    @(negedge clk);
    check("rm_mem_en", i, 64'(mem_en[i]), 64'd1);
    @(negedge clk);
    check("rm_state_wait", i, 64'(dbg_state[i]), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      exp_if_rd[j] = 32'h0;
      exp_d_rd[j]  = 32'h0;
    end
    check_quiet("rm_in_reset", i);
    rst = 1'b0;
    if_req[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rm_no_ack", i, 64'({if_ack[i], d_ack[i], busy[i]}), 64'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra;
    int ri;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b0; if_addr[i] = 32'h0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
      exp_if_rd[i] = 32'h0; exp_d_rd[i] = 32'h0;
      for (int a = 0; a < 256; a++) shadow[i][a] = pat(i, a);
    end
    do_reset(3);
    for (int i = 0; i < N; i++) check_quiet("reset", i);

    // Fetch at 0x10, MEM_LAT=1.
    txn(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    // Data read, then write followed by fetch read-back.
    txn(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    txn(0, 1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0);
    // Store 0xDEADBEEF to 0x100 at MEM_LAT=3, then read it back.
    txn(1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    txn(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    txn(2, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    // Request dropped and fields scrambled right after the grant.
    txn(1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 1'b1);
    txn(2, 1'b1, 1'b1, 32'h0000_0014, 32'hA5A5_0F0F, 1'b1);
    // Randomised single transactions.
    for (int r = 0; r < 8; r++) begin
      ri = $urandom_range(0, N - 1);
      ra = $urandom();
      ra[1:0] = 2'b00;
      txn(ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom(), 1'($urandom_range(0, 1)));
    end
    // Reset in WAIT at MEM_LAT=4, then a fresh fetch.
    reset_mid(2);
    txn(2, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    // Contention from a fresh reset.
    do_reset(2);
    both_req(0, 4);
    both_req(1, 4);

    check("sb_empty", 0, 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
